key_sequencer: RTL

Consumes the 5-bit `eBCD` key code stream from the keypad driver and assembles a calculation: first operand, operator, second operand, equals. It drives `operand1`/`operand2`/`operator` into the calculate block, pulses `calc_start`, and produces `fnd_serial` for the segment driver, showing the entry, the operator symbol, or the result. It is the receiving end of the keypad's eBCD interface.

---
 rtl/calc_defs.sv | 57 +++++
 rtl/key_edge_detect.sv | 25 ++
 rtl/key_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/calc_defs.sv
// Shared definitions for the calculator: eBCD key codes, operator codes,
// display symbol words, sequencer state encodings and small key helpers.
package calc_defs;

    // eBCD key codes from the keypad driver
    localparam logic [4:0] KEY_PLUS  = 5'h0A;
    localparam logic [4:0] KEY_MINUS = 5'h0B;
    localparam logic [4:0] KEY_MUL   = 5'h0C;
    localparam logic [4:0] KEY_DIV   = 5'h0D;
    localparam logic [4:0] KEY_MOD   = 5'h0E;
    localparam logic [4:0] KEY_EQ    = 5'h0F;
    localparam logic [4:0] KEY_CLR   = 5'h10;
    localparam logic [4:0] KEY_NONE  = 5'h1F;

    // Operator codes handed to the calculate block
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    // Display symbol words understood by the segment driver
    localparam logic signed [31:0] SYM_PLUS  = 32'sh0010_0000;
    localparam logic signed [31:0] SYM_MINUS = 32'sh0020_0000;
    localparam logic signed [31:0] SYM_MUL   = 32'sh0030_0000;
    localparam logic signed [31:0] SYM_DIV   = 32'sh0040_0000;
    localparam logic signed [31:0] SYM_MOD   = 32'sh0050_0000;
    localparam logic signed [31:0] SYM_ERR   = 32'sh00EE_0000;

    // Sequencer state encodings
    localparam logic [2:0] S_OP1  = 3'd0;
    localparam logic [2:0] S_OPR  = 3'd1;
    localparam logic [2:0] S_OP2  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_RES  = 3'd4;

    function automatic logic is_digit(input logic [4:0] k);
        return k <= 5'h09;
    endfunction

    function automatic logic is_operator(input logic [4:0] k);
        return (k >= KEY_PLUS) && (k <= KEY_MOD);
    endfunction

    // Operator keys are contiguous, so the code is the offset from '+'
    function automatic logic [2:0] op_code(input logic [4:0] k);
        return 3'(k - KEY_PLUS);
    endfunction

    // Symbol word for an operator: digit field holds operator+1
    function automatic logic signed [31:0] op_symbol(input logic [2:0] op);
        logic [3:0] s;
        s = {1'b0, op} + 4'd1;
        return {8'h00, s, 20'h00000};
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Turns the held eBCD key level into a single-cycle key event:
// an event fires on the first cycle a code appears after "no key".
module key_edge_detect
    import calc_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key_in,
    output logic       key_valid,
    output logic [4:0] key_code
);

    logic [4:0] prev;

    // Remember last cycle's key code; "no key" after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= KEY_NONE;
        else     prev <= key_in;
    end

    // Code changes without passing through "no key" never fire
    assign key_valid = (key_in != KEY_NONE) && (prev == KEY_NONE);
    assign key_code  = key_in;

endmodule

// File: rtl/key_sequencer.sv
// Assembles operand / operator / operand / equals from keypad events,
// launches the calculate block and drives the display word.
module key_sequencer
    import calc_defs::*;
#(
    parameter int MAX_DIGITS = 6
) (
    input  logic               sw_clk,
    input  logic               rst,
    input  logic        [4:0]  eBCD,
    input  logic signed [31:0] ans,
    output logic signed [31:0] operand1,
    output logic signed [31:0] operand2,
    output logic        [2:0]  operator,
    output logic               calc_start,
    output logic signed [31:0] fnd_serial
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] LIM_POS = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] LIM_NEG = CNT_W'(MAX_DIGITS - 1);

    logic              key_valid;
    logic [4:0]        key_code;
    logic [2:0]        state, state_nxt;
    logic [19:0]       acc, acc_nxt, acc_dig;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              neg, neg_nxt;
    logic              digit_ok;
    logic signed [31:0] op1_nxt, op2_nxt, val, val_nxt, fnd_nxt;
    logic [2:0]        opr_nxt;
    logic              start_nxt;

    // Entry magnitude plus sign flag as a 32-bit signed number
    function automatic logic signed [31:0] entry_value(input logic [19:0] a, input logic n);
        logic signed [31:0] m;
        m = signed'({12'h000, a});
        return n ? -m : m;
    endfunction

    key_edge_detect u_edge (
        .clk       (sw_clk),
        .rst       (rst),
        .key_in    (eBCD),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    // acc*10 + d as shift-add; a negative entry gives up one digit for the sign
    assign acc_dig  = (acc << 3) + (acc << 1) + {16'h0000, key_code[3:0]};
    assign digit_ok = cnt < (neg ? LIM_NEG : LIM_POS);
    assign val      = entry_value(acc, neg);
    assign val_nxt  = entry_value(acc_nxt, neg_nxt);

    // Next-state logic: FSM transitions, entry accumulation, operand latching
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        neg_nxt   = neg;
        op1_nxt   = operand1;
        op2_nxt   = operand2;
        opr_nxt   = operator;
        start_nxt = 1'b0;
        case (state)
            S_OP1: if (key_valid) begin
                if (is_digit(key_code)) begin
                    if (digit_ok) begin
                        acc_nxt = acc_dig;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (key_code == KEY_MINUS && cnt == '0 && !neg) begin
                    neg_nxt = 1'b1;
                end else if (is_operator(key_code) && cnt != '0) begin
                    op1_nxt   = val;
                    opr_nxt   = op_code(key_code);
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    neg_nxt   = 1'b0;
                    state_nxt = S_OPR;
                end
            end
            S_OPR: if (key_valid) begin
                if (is_digit(key_code)) begin
                    acc_nxt   = {16'h0000, key_code[3:0]};
                    cnt_nxt   = CNT_W'(1);
                    neg_nxt   = 1'b0;
                    state_nxt = S_OP2;
                end else if (is_operator(key_code)) begin
                    opr_nxt = op_code(key_code);
                end
            end
            S_OP2: if (key_valid) begin
                if (is_digit(key_code)) begin
                    if (digit_ok) begin
                        acc_nxt = acc_dig;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (key_code == KEY_EQ) begin
                    op2_nxt   = val;
                    start_nxt = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: state_nxt = S_RES;
            S_RES: if (key_valid) begin
                if (is_digit(key_code)) begin
                    acc_nxt   = {16'h0000, key_code[3:0]};
                    cnt_nxt   = CNT_W'(1);
                    neg_nxt   = 1'b0;
                    state_nxt = S_OP1;
                end else if (is_operator(key_code)) begin
                    op1_nxt   = ans;
                    opr_nxt   = op_code(key_code);
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    neg_nxt   = 1'b0;
                    state_nxt = S_OPR;
                end
            end
            default: state_nxt = S_OP1;
        endcase
        // Clear key wins in every state and wipes everything but the edge detector
        if (key_valid && key_code == KEY_CLR) begin
            state_nxt = S_OP1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            neg_nxt   = 1'b0;
            op1_nxt   = '0;
            op2_nxt   = '0;
            opr_nxt   = OP_ADD;
            start_nxt = 1'b0;
        end
    end

    // Display word follows the state being entered; the result is only taken
    // once the sequencer has sat in S_RES for a cycle so ans has settled
    always_comb begin
        fnd_nxt = '0;
        case (state_nxt)
            S_OP1:  fnd_nxt = (cnt_nxt != '0) ? val_nxt : (neg_nxt ? SYM_MINUS : '0);
            S_OP2:  fnd_nxt = (cnt_nxt != '0) ? val_nxt : '0;
            S_OPR:  fnd_nxt = op_symbol(opr_nxt);
            S_WAIT: fnd_nxt = fnd_serial;
            S_RES:  fnd_nxt = (state == S_RES) ? ans : fnd_serial;
            default: fnd_nxt = '0;
        endcase
    end

    // State, entry and output registers
    always_ff @(posedge sw_clk or posedge rst) begin
        if (rst) begin
            state      <= S_OP1;
            acc        <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            operand1   <= '0;
            operand2   <= '0;
            operator   <= OP_ADD;
            calc_start <= 1'b0;
            fnd_serial <= '0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            neg        <= neg_nxt;
            operand1   <= op1_nxt;
            operand2   <= op2_nxt;
            operator   <= opr_nxt;
            calc_start <= start_nxt;
            fnd_serial <= fnd_nxt;
        end
    end

endmodule
